// File: rtl/imem_pkg.sv
// Shared types and address-map constants for the instruction fetch path.
// Fetch entries pair a PC with its instruction word so decode sees them together.
package imem_pkg;

    localparam logic [31:0] IMEM_BASE  = 32'h0100_0000;
    localparam logic [31:0] IMEM_LIMIT = 32'h0100_07FF;
    localparam logic [31:0] RESET_PC   = 32'h0100_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    // The last byte of the word is computed in 33 bits so a near-2^32 address cannot wrap into range.
    function automatic logic imem_addr_legal(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] limit
    );
        logic [32:0] last_byte;
        last_byte = {1'b0, addr} + 33'd3;
        return (addr[1:0] == 2'b00) && (addr >= base) && (last_byte <= {1'b0, limit});
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO holding fetched {pc, instr} pairs between the memory response and decode.
// Flush drops all entries; the caller never pushes into a full buffer.
module fetch_skid_buf
    import imem_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator: drives the 1-cycle-latency memory address, buffers responses,
// and hands {pc, instr} pairs to decode. Halts with a sticky fault on an illegal fetch address.
module instr_fetch_unit
    import imem_pkg::fetch_entry_t, imem_pkg::fetch_state_e, imem_pkg::ST_RUN,
           imem_pkg::ST_HALT, imem_pkg::imem_addr_legal;
#(
    parameter logic [31:0] RESET_PC   = imem_pkg::RESET_PC,
    parameter logic [31:0] IMEM_BASE  = imem_pkg::IMEM_BASE,
    parameter logic [31:0] IMEM_LIMIT = imem_pkg::IMEM_LIMIT
)(
    input  logic         clk,
    input  logic         rst_n,
    output logic [31:0]  instr_addr,
    input  logic [31:0]  instr,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_pc,
    output logic [31:0]  out_instr,
    output logic         fault,
    output logic [31:0]  fault_pc,
    output fetch_state_e o_dbg_state,
    output logic [1:0]   o_dbg_count
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic         r_fault;
    logic         w_fault_nxt;
    logic [31:0]  r_fault_pc;
    logic [31:0]  w_fault_pc_nxt;
    logic [31:0]  r_pc;
    logic         r_inflight;
    logic [31:0]  r_inflight_pc;

    logic [31:0]  w_issue_addr;
    logic         w_addr_legal;
    logic         w_issue;
    logic         w_pop;
    logic         w_head_valid;
    logic [2:0]   w_occupancy;
    logic         w_push;
    fetch_entry_t w_push_data;
    fetch_entry_t w_head;
    logic [1:0]   w_count;

    assign w_issue_addr = redirect_valid ? redirect_pc : r_pc;
    assign w_addr_legal = imem_addr_legal(w_issue_addr, IMEM_BASE, IMEM_LIMIT);
    assign instr_addr   = w_issue_addr;

    // Decode handshake: an entry transfers on a cycle where out_valid and out_ready are both 1;
    // out_valid never depends on out_ready, and the head stays stable until it transfers.
    // A redirect cycle suppresses out_valid so nothing older than the redirect is consumed.
    assign w_head_valid = (w_count != 2'd0);
    assign out_valid    = w_head_valid & ~redirect_valid;
    assign w_pop        = out_valid & out_ready;

    // Entries buffered plus the one in flight, after this cycle's pop; a redirect discards both.
    assign w_occupancy = redirect_valid ? 3'd0
                       : ({1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop});
    assign w_issue = (redirect_valid || (r_state == ST_RUN)) && w_addr_legal
                   && (w_occupancy < 3'd2);

    assign w_push      = r_inflight & ~redirect_valid;
    assign w_push_data = '{pc: r_inflight_pc, instr: instr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_fault    <= 1'b0;
            r_fault_pc <= 32'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_fault    <= w_fault_nxt;
            r_fault_pc <= w_fault_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fault_nxt    = r_fault;
        w_fault_pc_nxt = r_fault_pc;
        if (redirect_valid) begin
            if (w_addr_legal) begin
                w_state_nxt = ST_RUN;
                w_fault_nxt = 1'b0;
            end else begin
                w_state_nxt    = ST_HALT;
                w_fault_nxt    = 1'b1;
                w_fault_pc_nxt = redirect_pc;
            end
        end else if ((r_state == ST_RUN) && !w_addr_legal) begin
            w_state_nxt    = ST_HALT;
            w_fault_nxt    = 1'b1;
            w_fault_pc_nxt = r_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
        end else if (w_issue) begin
            r_inflight    <= 1'b1;
            r_inflight_pc <= w_issue_addr;
            r_pc          <= w_issue_addr + 32'd4;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    fetch_skid_buf u_skid_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign out_pc      = w_head_valid ? w_head.pc    : 32'h0;
    assign out_instr   = w_head_valid ? w_head.instr : 32'h0;
    assign fault       = r_fault;
    assign fault_pc    = r_fault_pc;
    assign o_dbg_state = r_state;
    assign o_dbg_count = w_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle registered-address memory model.
// Word k of memory is 32'hC0DE_0000 ^ k, so every delivered instr can be tied to its pc.
module tb_instr_fetch_unit;
    import imem_pkg::*;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic                clk;
    logic                rst_n;
    logic [31:0]         instr_addr;
    logic [31:0]         instr;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_pc;
    logic [31:0]         out_instr;
    logic                fault;
    logic [31:0]         fault_pc;
    fetch_state_e        dbg_state;
    logic [1:0]          dbg_count;

    int                  n_checks;
    int                  n_pass;
    logic [31:0]         exp_pc;
    logic [31:0]         mem_addr_q;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_addr     (instr_addr),
        .instr          (instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .o_dbg_state    (dbg_state),
        .o_dbg_count    (dbg_count)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return 32'hC0DE_0000 ^ ((addr - BASE) >> 2);
    endfunction

    always_ff @(posedge clk) mem_addr_q <= instr_addr;
    assign instr = word_at(mem_addr_q);

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_pc !== 32'h0) $display("FAIL reset_pc got %h exp 0", out_pc); else n_pass++;
        n_checks++; if (out_instr !== 32'h0) $display("FAIL reset_instr got %h exp 0", out_instr); else n_pass++;
        n_checks++; if (fault !== 1'b0 || fault_pc !== 32'h0) $display("FAIL reset_fault got %b/%h exp 0/0", fault, fault_pc); else n_pass++;
        n_checks++; if (instr_addr !== RESET_PC) $display("FAIL reset_addr got %h exp %h", instr_addr, RESET_PC); else n_pass++;
        n_checks++; if (dbg_state !== ST_RUN || dbg_count !== 2'd0) $display("FAIL reset_state got %0d/%0d exp 0/0", dbg_state, dbg_count); else n_pass++;
    endtask

    task automatic test_stream;
        rst_n = 1'b1; #1;
        n_checks++; if (instr_addr !== RESET_PC || out_valid !== 1'b0) $display("FAIL stream_c0 got %h/%b exp %h/0", instr_addr, out_valid, RESET_PC); else n_pass++;
        tick; #1;
        n_checks++; if (instr_addr !== RESET_PC + 32'd4 || out_valid !== 1'b0) $display("FAIL stream_c1 got %h/%b exp %h/0", instr_addr, out_valid, RESET_PC + 32'd4); else n_pass++;
        tick; #1;
        n_checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC || out_instr !== word_at(RESET_PC)) $display("FAIL stream_first got %b/%h/%h exp 1/%h/%h", out_valid, out_pc, out_instr, RESET_PC, word_at(RESET_PC)); else n_pass++;
        exp_pc = RESET_PC + 32'd4;
        for (int i = 0; i < 8; i++) begin
            tick; #1;
            n_checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== word_at(exp_pc)) $display("FAIL stream_seq got %b/%h/%h exp 1/%h/%h", out_valid, out_pc, out_instr, exp_pc, word_at(exp_pc)); else n_pass++;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_backpressure;
        tick; out_ready = 1'b0; #1;
        n_checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc) $display("FAIL stall_head got %b/%h exp 1/%h", out_valid, out_pc, exp_pc); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick; #1;
            n_checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== word_at(exp_pc) || dbg_count > 2'd2) $display("FAIL stall_hold got %b/%h/%h cnt %0d exp 1/%h/%h", out_valid, out_pc, out_instr, dbg_count, exp_pc, word_at(exp_pc)); else n_pass++;
        end
        n_checks++; if (dbg_count !== 2'd2) $display("FAIL stall_full got %0d exp 2", dbg_count); else n_pass++;
        tick; out_ready = 1'b1; #1;
        n_checks++; if (out_pc !== exp_pc) $display("FAIL stall_release got %h exp %h", out_pc, exp_pc); else n_pass++;
        exp_pc = exp_pc + 32'd4;
        for (int i = 0; i < 6; i++) begin
            tick; #1;
            n_checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== word_at(exp_pc)) $display("FAIL stall_resume got %b/%h/%h exp 1/%h/%h", out_valid, out_pc, out_instr, exp_pc, word_at(exp_pc)); else n_pass++;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_redirect;
        tick; out_ready = 1'b0; #1;
        n_checks++; if (out_pc !== exp_pc) $display("FAIL redir_pre got %h exp %h", out_pc, exp_pc); else n_pass++;
        tick; out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0100_0100; #1;
        n_checks++; if (out_valid !== 1'b0 || instr_addr !== 32'h0100_0100 || dbg_count !== 2'd2) $display("FAIL redir_cycle got %b/%h cnt %0d exp 0/01000100 cnt 2", out_valid, instr_addr, dbg_count); else n_pass++;
        tick; redirect_valid = 1'b0; #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL redir_gap got %b exp 0", out_valid); else n_pass++;
        tick; #1;
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0100_0100 || out_instr !== word_at(32'h0100_0100)) $display("FAIL redir_first got %b/%h/%h exp 1/01000100/%h", out_valid, out_pc, out_instr, word_at(32'h0100_0100)); else n_pass++;
        exp_pc = 32'h0100_0104;
        for (int i = 0; i < 3; i++) begin
            tick; #1;
            n_checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc) $display("FAIL redir_seq got %b/%h exp 1/%h", out_valid, out_pc, exp_pc); else n_pass++;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_top_of_range;
        tick; redirect_valid = 1'b1; redirect_pc = 32'h0100_07F0; #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL top_redir got %b exp 0", out_valid); else n_pass++;
        tick; redirect_valid = 1'b0; #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL top_gap got %b exp 0", out_valid); else n_pass++;
        exp_pc = 32'h0100_07F0;
        for (int i = 0; i < 4; i++) begin
            tick; #1;
            n_checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== word_at(exp_pc)) $display("FAIL top_seq got %b/%h/%h exp 1/%h/%h", out_valid, out_pc, out_instr, exp_pc, word_at(exp_pc)); else n_pass++;
            exp_pc = exp_pc + 32'd4;
        end
        n_checks++; if (fault !== 1'b1 || fault_pc !== 32'h0100_0800 || instr_addr !== 32'h0100_0800 || dbg_state !== ST_HALT) $display("FAIL top_fault got %b/%h addr %h st %0d exp 1/01000800 addr 01000800 st 1", fault, fault_pc, instr_addr, dbg_state); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick; #1;
            n_checks++; if (out_valid !== 1'b0 || fault !== 1'b1) $display("FAIL top_drained got %b/%b exp 0/1", out_valid, fault); else n_pass++;
        end
        tick; redirect_valid = 1'b1; redirect_pc = BASE; #1;
        tick; redirect_valid = 1'b0; #1;
        n_checks++; if (fault !== 1'b0 || dbg_state !== ST_RUN) $display("FAIL top_clear got %b st %0d exp 0 st 0", fault, dbg_state); else n_pass++;
        tick; #1;
        n_checks++; if (out_valid !== 1'b1 || out_pc !== BASE) $display("FAIL top_resume got %b/%h exp 1/%h", out_valid, out_pc, BASE); else n_pass++;
        tick; #1;
        n_checks++; if (out_valid !== 1'b1 || out_pc !== BASE + 32'd4) $display("FAIL top_resume2 got %b/%h exp 1/%h", out_valid, out_pc, BASE + 32'd4); else n_pass++;
    endtask

    task automatic test_illegal_redirect;
        logic [31:0] bad [2];
        bad[0] = 32'h0100_0102;
        bad[1] = 32'h00FF_FFFC;
        for (int b = 0; b < 2; b++) begin
            tick; redirect_valid = 1'b1; redirect_pc = bad[b]; #1;
            n_checks++; if (out_valid !== 1'b0) $display("FAIL bad_redir_cycle got %b exp 0", out_valid); else n_pass++;
            tick; redirect_valid = 1'b0; #1;
            n_checks++; if (fault !== 1'b1 || fault_pc !== bad[b] || dbg_state !== ST_HALT) $display("FAIL bad_fault got %b/%h st %0d exp 1/%h st 1", fault, fault_pc, dbg_state, bad[b]); else n_pass++;
            for (int i = 0; i < 3; i++) begin
                tick; #1;
                n_checks++; if (out_valid !== 1'b0) $display("FAIL bad_quiet got %b exp 0", out_valid); else n_pass++;
            end
        end
        tick; redirect_valid = 1'b1; redirect_pc = 32'h0100_0200; #1;
        tick; redirect_valid = 1'b0; #1;
        n_checks++; if (fault !== 1'b0) $display("FAIL bad_clear got %b exp 0", fault); else n_pass++;
        tick; #1;
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0100_0200 || out_instr !== word_at(32'h0100_0200)) $display("FAIL bad_resume got %b/%h/%h exp 1/01000200/%h", out_valid, out_pc, out_instr, word_at(32'h0100_0200)); else n_pass++;
    endtask

    task automatic test_reset_mid;
        tick; out_ready = 1'b0;
        tick; tick; #1;
        n_checks++; if (dbg_count !== 2'd2) $display("FAIL rmid_fill got %0d exp 2", dbg_count); else n_pass++;
        rst_n = 1'b0; #1;
        n_checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || dbg_count !== 2'd0) $display("FAIL rmid_out got %b/%h/%h cnt %0d exp 0/0/0 cnt 0", out_valid, out_pc, out_instr, dbg_count); else n_pass++;
        n_checks++; if (instr_addr !== RESET_PC || fault !== 1'b0) $display("FAIL rmid_addr got %h/%b exp %h/0", instr_addr, fault, RESET_PC); else n_pass++;
        out_ready = 1'b1;
        tick; rst_n = 1'b1; #1;
        n_checks++; if (instr_addr !== RESET_PC || out_valid !== 1'b0) $display("FAIL rmid_c0 got %h/%b exp %h/0", instr_addr, out_valid, RESET_PC); else n_pass++;
        tick; #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_c1 got %b exp 0", out_valid); else n_pass++;
        tick; #1;
        n_checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC || out_instr !== word_at(RESET_PC)) $display("FAIL rmid_first got %b/%h/%h exp 1/%h/%h", out_valid, out_pc, out_instr, RESET_PC, word_at(RESET_PC)); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_top_of_range();
        test_illegal_redirect();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read port: generates the byte address each cycle and consumes the returned 32-bit word.
- The memory registers the address on the clock and returns the word combinationally from that registered address, so read latency is exactly 1 cycle.
- Delivers {pc, instr} pairs in program order to decode over a valid/ready handshake.
- Supports redirect (branch/jump/trap) and halts on illegal fetch addresses.

Parameters:
- RESET_PC, 32'h0100_0000, first fetch address after reset
- IMEM_BASE, 32'h0100_0000, lowest legal byte address
- IMEM_LIMIT, 32'h0100_07FF, highest legal byte address (inclusive)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_addr  out  32  byte address presented to instruction memory this cycle
- instr  in  32  word from memory for the address presented the previous cycle
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode accepts head entry
- out_pc  out  32  PC of head entry
- out_instr  out  32  instruction of head entry
- fault  out  1  fetch halted on illegal address (sticky until redirect)
- fault_pc  out  32  offending address

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, instr_addr=RESET_PC, inflight=0, buffer empty.
  - out_valid=0, out_pc=0, out_instr=0, fault=0, fault_pc=0, state=RUN.
- Legal address: pc[1:0]==0 and IMEM_BASE<=pc and pc+3<=IMEM_LIMIT.
  - Compute pc+3 in 33 bits so the check cannot wrap.
- States:
  - RUN: issues fetches.
  - HALT: no issue; entered on an illegal issue address; left only on redirect_valid.
- Issue condition: state==RUN, addr legal, and (count + inflight - pop) < 2.
  - count: buffer occupancy (0..2). pop = out_valid & out_ready.
- Issue address:
  - redirect_valid=1: issue address is redirect_pc.
  - Otherwise: issue address is pc.
  - instr_addr always equals the issue address, issued or not. A response is kept only when inflight=1.
- On issue:
  - inflight<=1, inflight_pc<=issue address, pc<=issue address+4.
  - Otherwise inflight<=0 and pc holds.
- Response: when inflight=1, {inflight_pc, instr} is written into the 2-entry buffer at the end of that cycle.
- Latency:
  - Address issued at cycle N returns at N+1 and is visible as out_valid at N+2.
  - Steady-state throughput is 1 instruction per cycle with out_ready=1.
- Redirect cycle:
  - Buffer flushed and current inflight response discarded.
  - out_valid forced 0, so no transfer occurs that cycle even if out_ready=1.
  - fault cleared, state<=RUN.
  - If redirect_pc is legal: it issues that cycle, first out_valid at N+2.
  - If redirect_pc is illegal: fault=1, fault_pc=redirect_pc next cycle, state<=HALT.
- Illegal sequential address, e.g. pc=IMEM_LIMIT+1:
  - No issue; state<=HALT, fault<=1, fault_pc<=pc.
  - Entries already buffered or inflight still drain normally.
- Backpressure:
  - out_ready=0 holds the head entry stable.
  - The issue rule guarantees the buffer never overflows and no response is lost.
- Simultaneous pop and response write at count==2 cannot occur by construction. At count==1 the count stays 1.
- pc+4 wraps mod 2^32. Wrap is always caught by the legal check.

Decomposition:
- Package imem_pkg:
  - IMEM_BASE, IMEM_LIMIT, RESET_PC constants.
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
  - Function imem_addr_legal().
- Sub-module fetch_skid_buf: 2-entry FIFO of fetch_entry_t.
  - Ports: push, push data, pop, flush, head, count.
  - Async active-low reset.
- Top level holds pc, inflight, the state FSM, fault registers and the issue logic.

Test Plan:
- Reset release, out_ready=1, memory preloaded with word k at 0x01000000+4k:
  - instr_addr=0x01000000 at cycle 0.
  - out_valid at cycle 2 with out_pc=0x01000000.
  - Then out_pc increments by 4 every cycle with matching instr.
- out_ready low for 5 cycles mid-stream:
  - No entry dropped or duplicated; out_pc sequence stays contiguous.
  - Buffer count never exceeds 2; head stable while stalled.
- redirect_pc=0x01000100 while 2 entries buffered and 1 inflight:
  - out_valid=0 in the redirect cycle.
  - Next delivered out_pc=0x01000100 two cycles later; no stale PCs delivered.
- Sequential fetch to top of range:
  - 0x010007FC delivered.
  - Next issue 0x01000800 blocked; fault=1, fault_pc=0x01000800, out_valid falls once drained.
  - A subsequent redirect to 0x01000000 clears fault and resumes.
- redirect_pc=0x01000102 (misaligned) and redirect_pc=0x00FFFFFC (below base):
  - fault=1 with that fault_pc; no further out_valid until a legal redirect.
- rst_n asserted mid-stream with entries buffered:
  - Outputs immediately return to reset values.
  - After release, fetch restarts at RESET_PC with first out_valid 2 cycles later.
